// File: rtl/vfifo_pkg.sv
// Shared sizing helpers for the versatile FIFO family.
package vfifo_pkg;

   localparam int unsigned VFIFO_FLAG_WIDTH = 1;

   function automatic int unsigned vfifo_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

   // Level must represent 0..DEPTH inclusive, hence one extra bit.
   function automatic int unsigned vfifo_level_width(input int unsigned addr_width);
      return addr_width + 32'd1;
   endfunction

endpackage

// File: rtl/vfifo_dual_port_ram_sc_dw.sv
// Single-clock true dual-port RAM, both ports with registered read (read-first).
module vfifo_dual_port_ram_sc_dw #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] adr_a,
   input  logic [DATA_WIDTH-1:0] d_a,
   output logic [DATA_WIDTH-1:0] q_a,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] adr_b,
   input  logic [DATA_WIDTH-1:0] d_b,
   output logic [DATA_WIDTH-1:0] q_b
);

   logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we_a) mem[adr_a] <= d_a;
      if (we_b) mem[adr_b] <= d_b;
      q_a <= mem[adr_a];
      q_b <= mem[adr_b];
   end

endmodule

// File: rtl/vfifo_sc_fwft_ctrl.sv
// Single-clock first-word-fall-through FIFO controller; port A writes, port B
// prefetches the head entry so pop_data is valid whenever pop_valid is set.
module vfifo_sc_fwft_ctrl
   import vfifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned AF_LEVEL   = vfifo_depth(ADDR_WIDTH) - 4,
   parameter int unsigned AE_LEVEL   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_valid,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned LW = vfifo_level_width(ADDR_WIDTH);
   localparam logic [LW-1:0] DEPTH_L = LW'(vfifo_depth(ADDR_WIDTH));
   localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
   localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

   logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
   logic [LW-1:0]         ram_cnt_reg, ram_cnt_next;
   logic                  head_valid_reg, head_valid_next;
   logic                  overflow_reg, underflow_reg;

   logic                  do_wr, do_pop, do_fetch;
   logic [ADDR_WIDTH-1:0] adr_b;
   logic [DATA_WIDTH-1:0] q_a_unused;

   assign level        = ram_cnt_reg + {{(LW-1){1'b0}}, head_valid_reg};
   assign full         = (level == DEPTH_L);
   assign almost_full  = (level >= AF_L);
   assign almost_empty = (level <= AE_L);
   assign pop_valid    = head_valid_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

   assign do_wr    = push & ~full;
   assign do_pop   = pop & head_valid_reg;
   assign do_fetch = (ram_cnt_reg != '0) & (~head_valid_reg | do_pop);

   // Outside fetch cycles keep re-reading the head slot so q_b holds steady.
   assign adr_b = do_fetch ? rd_ptr_reg : rd_ptr_reg - ADDR_WIDTH'(1);

   always_comb begin
      wr_ptr_next     = wr_ptr_reg;
      rd_ptr_next     = rd_ptr_reg;
      ram_cnt_next    = ram_cnt_reg;
      head_valid_next = do_fetch | (head_valid_reg & ~do_pop);
      if (do_wr)    wr_ptr_next = wr_ptr_reg + ADDR_WIDTH'(1);
      if (do_fetch) rd_ptr_next = rd_ptr_reg + ADDR_WIDTH'(1);
      case ({do_wr, do_fetch})
         2'b10:   ram_cnt_next = ram_cnt_reg + LW'(1);
         2'b01:   ram_cnt_next = ram_cnt_reg - LW'(1);
         default: ram_cnt_next = ram_cnt_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         ram_cnt_reg    <= '0;
         head_valid_reg <= 1'b0;
         overflow_reg   <= 1'b0;
         underflow_reg  <= 1'b0;
      end else if (clear) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         ram_cnt_reg    <= '0;
         head_valid_reg <= 1'b0;
         overflow_reg   <= 1'b0;
         underflow_reg  <= 1'b0;
      end else begin
         wr_ptr_reg     <= wr_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         ram_cnt_reg    <= ram_cnt_next;
         head_valid_reg <= head_valid_next;
         overflow_reg   <= push & full;
         underflow_reg  <= pop & ~head_valid_reg;
      end
   end

   vfifo_dual_port_ram_sc_dw #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we_a  (do_wr),
      .adr_a (wr_ptr_reg),
      .d_a   (push_data),
      .q_a   (q_a_unused),
      .we_b  (1'b0),
      .adr_b (adr_b),
      .d_b   ({DATA_WIDTH{1'b0}}),
      .q_b   (pop_data)
   );

endmodule

// File: tb/tb_vfifo_sc_fwft_ctrl.sv
// Scenario bench for vfifo_sc_fwft_ctrl (depth 4) with a data scoreboard.
module tb_vfifo_sc_fwft_ctrl;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          push = 1'b0;
   logic [DW-1:0] push_data = '0;
   logic          full, almost_full, pop_valid, almost_empty;
   logic          pop = 1'b0;
   logic [DW-1:0] pop_data;
   logic [AW:0]   level;
   logic          overflow, underflow;

   int tests_run = 0;
   int tests_failed = 0;

   logic [DW-1:0] sb[$];
   int  m_cnt = 0;
   bit  m_head = 1'b0;
   int  pops_seen = 0;

   vfifo_sc_fwft_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .AF_LEVEL   (3),
      .AE_LEVEL   (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .push         (push),
      .push_data    (push_data),
      .full         (full),
      .almost_full  (almost_full),
      .pop          (pop),
      .pop_data     (pop_data),
      .pop_valid    (pop_valid),
      .almost_empty (almost_empty),
      .level        (level),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   // Drives one cycle from a negedge, compares popped data against the
   // scoreboard, advances the reference occupancy model, returns at next negedge.
   task automatic drive_cycle(input bit p, input logic [DW-1:0] d, input bit q, input bit c);
      bit m_full, wr, dp, f;
      logic [DW-1:0] exp_d;
      push = p; push_data = d; pop = q; clear = c;
      if (q && m_head && !c) begin
         tests_run++;
         if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_pop: pop accepted with data %h but scoreboard empty", pop_data);
         end else begin
            exp_d = sb.pop_front();
            pops_seen++;
            if (pop_data !== exp_d) begin
               tests_failed++;
               $display("FAIL pop_data: got %h expected %h", pop_data, exp_d);
            end
         end
      end
      if (c) begin
         m_cnt = 0; m_head = 1'b0; sb.delete();
      end else begin
         m_full = ((m_cnt + int'(m_head)) == 4);
         wr = p && !m_full;
         dp = q && m_head;
         f  = (m_cnt != 0) && (!m_head || dp);
         m_cnt = m_cnt + int'(wr) - int'(f);
         m_head = f || (m_head && !dp);
         if (wr) sb.push_back(d);
      end
      @(posedge clk);
      @(negedge clk);
      push = 1'b0; pop = 1'b0; clear = 1'b0;
      $display("[TB] cyc push=%0b d=%h pop=%0b clr=%0b -> level=%0d pv=%0b ovf=%0b udf=%0b",
               p, d, q, c, level, pop_valid, overflow, underflow);
   endtask

   task automatic drain();
      for (int i = 0; i < 8; i++) begin
         if (m_head || m_cnt != 0) drive_cycle(1'b0, 8'h00, m_head, 1'b0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({level, full, almost_full, almost_empty, pop_valid, overflow, underflow} !== {3'd0, 6'b001000}) begin
         tests_failed++;
         $display("FAIL reset_outputs: got level=%0d f=%b af=%b ae=%b pv=%b ov=%b un=%b required 0 0 0 1 0 0 0",
                  level, full, almost_full, almost_empty, pop_valid, overflow, underflow);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_first_word();
      drive_cycle(1'b1, 8'h11, 1'b0, 1'b0);
      tests_run++;
      if (pop_valid !== 1'b0 || level !== 3'd1 || almost_empty !== 1'b1) begin
         tests_failed++;
         $display("FAIL first_edge: got pv=%b level=%0d ae=%b required pv=0 level=1 ae=1", pop_valid, level, almost_empty);
      end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      tests_run++;
      if (pop_valid !== 1'b1 || pop_data !== 8'h11 || level !== 3'd1 || almost_empty !== 1'b1) begin
         tests_failed++;
         $display("FAIL first_valid: got pv=%b data=%h level=%0d ae=%b required 1 11 1 1", pop_valid, pop_data, level, almost_empty);
      end
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      tests_run++;
      if (level !== 3'd0 || pop_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL first_drain: got level=%0d pv=%b required 0 0", level, pop_valid);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
         if (i == 2) begin
            tests_run++;
            if (almost_full !== 1'b1 || full !== 1'b0 || level !== 3'd3) begin
               tests_failed++;
               $display("FAIL level3_flags: got af=%b full=%b level=%0d required af=1 full=0 level=3", almost_full, full, level);
            end
         end
      end
      tests_run++;
      if (full !== 1'b1 || level !== 3'd4) begin
         tests_failed++;
         $display("FAIL fill_full: got full=%b level=%0d required full=1 level=4", full, level);
      end
      drive_cycle(1'b1, 8'hA4, 1'b0, 1'b0);
      tests_run++;
      if (overflow !== 1'b1 || level !== 3'd4) begin
         tests_failed++;
         $display("FAIL overflow_pulse: got ovf=%b level=%0d required ovf=1 level=4", overflow, level);
      end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL overflow_once: got ovf=%b required 0", overflow);
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (pop_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pop_gap: pop %0d got pv=%b required 1", i, pop_valid);
         end
         drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
      tests_run++;
      if (level !== 3'd0 || pop_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL fill_drained: got level=%0d pv=%b required 0 0", level, pop_valid);
      end
   endtask

   task automatic test_back_to_back();
      int start_pops;
      int bad_level;
      start_pops = pops_seen;
      bad_level = 0;
      for (int i = 0; i < 20; i++) begin
         drive_cycle(1'b1, 8'(i), m_head, 1'b0);
         if (level < 3'd1 || level > 3'd2 || level !== 3'(m_cnt + int'(m_head))) bad_level++;
      end
      tests_run++;
      if (bad_level != 0) begin
         tests_failed++;
         $display("FAIL b2b_level: %0d cycles with level outside model/1..2, required 0", bad_level);
      end
      tests_run++;
      if (pops_seen - start_pops < 18) begin
         tests_failed++;
         $display("FAIL b2b_throughput: got %0d pops in 20 cycles required >= 18", pops_seen - start_pops);
      end
      drain();
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
      drive_cycle(1'b1, 8'hEE, 1'b1, 1'b0);
      tests_run++;
      if (overflow !== 1'b1 || level !== 3'd3 || full !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_push_pop: got ovf=%b level=%0d full=%b required 1 3 0", overflow, level, full);
      end
      drain();
      tests_run++;
      if (level !== 3'd0) begin
         tests_failed++;
         $display("FAIL full_drain: got level=%0d required 0", level);
      end
   endtask

   task automatic test_underflow();
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      tests_run++;
      if (underflow !== 1'b1 || level !== 3'd0 || pop_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL underflow_pulse: got udf=%b level=%0d pv=%b required 1 0 0", underflow, level, pop_valid);
      end
      drive_cycle(1'b1, 8'h33, 1'b0, 1'b0);
      tests_run++;
      if (underflow !== 1'b0 || level !== 3'd1) begin
         tests_failed++;
         $display("FAIL underflow_once: got udf=%b level=%0d required 0 1", underflow, level);
      end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      drain();
   endtask

   task automatic test_clear();
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      drive_cycle(1'b1, 8'hC3, 1'b0, 1'b1);
      tests_run++;
      if (level !== 3'd0 || pop_valid !== 1'b0 || overflow !== 1'b0 || almost_empty !== 1'b1) begin
         tests_failed++;
         $display("FAIL clear_state: got level=%0d pv=%b ovf=%b ae=%b required 0 0 0 1", level, pop_valid, overflow, almost_empty);
      end
      drive_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      tests_run++;
      if (pop_valid !== 1'b1 || pop_data !== 8'h5A) begin
         tests_failed++;
         $display("FAIL clear_refill: got pv=%b data=%h required 1 5a", pop_valid, pop_data);
      end
      drain();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({level, full, almost_full, almost_empty, pop_valid, overflow, underflow} !== {3'd0, 6'b001000}) begin
         tests_failed++;
         $display("FAIL async_reset: got level=%0d f=%b af=%b ae=%b pv=%b ov=%b un=%b required 0 0 0 1 0 0 0",
                  level, full, almost_full, almost_empty, pop_valid, overflow, underflow);
      end
      m_cnt = 0; m_head = 1'b0; sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      drive_cycle(1'b1, 8'h77, 1'b0, 1'b0);
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      drain();
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("FAIL sb_leftover: got %0d unpopped entries required 0", sb.size());
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_first_word();
      test_fill_overflow();
      test_back_to_back();
      test_full_push_pop();
      test_underflow();
      test_clear();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
